inst_queue: RTL
===============

Name: inst_queue

Overview:
- Instruction buffer between the fetch unit and the two decode ways; dec_way instances consume its outputs.
- Takes 2-wide fetch bundles (instruction plus PC per slot) and stores them in a circular FIFO.
- Presents up to 2 oldest instructions per cycle to decode, in program order.
- Decouples fetch stalls from decode/dispatch stalls and provides a single-cycle flush for redirects.

Parameters:
- DEPTH, 8, number of instruction entries; power of 2, >= 4.
- PC_W, 64, width of stored PC.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all queued entries (branch redirect/exception).
- fet_valid_i  in  2  per-slot valid of incoming bundle; bit0 = older slot.
- fet_inst0_i  in  32  slot-0 instruction.
- fet_inst1_i  in  32  slot-1 instruction.
- fet_pc0_i  in  PC_W  slot-0 PC.
- fet_pc1_i  in  PC_W  slot-1 PC.
- fet_ready_o  out  1  queue can accept a full bundle this cycle.
- dec_valid_o  out  2  per-slot valid to decode ways; bit0 = oldest.
- dec_inst0_o  out  32  oldest instruction.
- dec_inst1_o  out  32  second-oldest instruction.
- dec_pc0_o  out  PC_W  PC of oldest instruction.
- dec_pc1_o  out  PC_W  PC of second-oldest instruction.
- dec_ready_i  in  1  decode consumes every valid output slot this cycle.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
Reset:
- Synchronous on rst_i: rd_ptr = wr_ptr = count = 0.
- During reset: dec_valid_o = 2'b00, fet_ready_o = 0, count_o = 0.
- Entry storage is not reset; data outputs are don't-care while the corresponding valid bit is 0.

Storage and pointers:
- Circular array of DEPTH entries {inst[31:0], pc[PC_W-1:0]}.
- rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is $clog2(DEPTH)+1 bits, range 0..DEPTH.

Enqueue:
- fet_ready_o = (DEPTH - count >= 2) && !rst_i. It depends on current count only; same-cycle dequeue never raises it.
- Enqueue fires when fet_ready_o && |fet_valid_i.
- Valid slots are written in order from wr_ptr, compacting around any invalid slot:
  - 2'b11: slot0 to wr_ptr, slot1 to wr_ptr+1.
  - 2'b01: slot0 only.
  - 2'b10: slot1 written to wr_ptr.
- wr_ptr advances by popcount(fet_valid_i).
- fet_valid_i != 0 while fet_ready_o = 0: ignored. Fetch must hold the bundle.

Dequeue:
- dec_valid_o[0] = (count >= 1); dec_valid_o[1] = (count >= 2).
- dec_*0_o reads entry rd_ptr; dec_*1_o reads entry rd_ptr+1 (wrapped).
- On dec_ready_i, rd_ptr advances by popcount(dec_valid_o). Partial acceptance is not supported.
- dec_ready_i with count = 0: no effect.

Count and latency:
- Next count = count + enq_n - deq_n.
- Enqueue and dequeue in the same cycle are allowed, including at count = DEPTH-2 and when count = 1 with a 2-slot enqueue.
- Latency without bypass: instruction enqueued in cycle N appears on dec outputs in cycle N+1 at the earliest.
- Program order is preserved across pointer wrap.

Flush and boundaries:
- flush_i sets rd_ptr = wr_ptr = count = 0 next cycle.
- flush_i has priority over enqueue and dequeue in the same cycle; the incoming bundle is dropped.
- flush_i is combinationally ignored on outputs: dec_valid_o in the flush cycle still reflects pre-flush contents.
- Reset asserted mid-operation behaves identically to flush, plus the fet_ready_o = 0 gating.
- Full (count = DEPTH) and count = DEPTH-1: fet_ready_o = 0.
- Empty: dec_valid_o = 0.

Optional Feature:
INST_QUEUE_BYPASS_EN
- Defined: when count = 0, !flush_i and enqueue fires, incoming valid slots (after compaction) drive dec_* outputs combinationally in the same cycle.
  - If dec_ready_i is also high, the bypassed slots are not written and pointers/count stay 0.
  - Otherwise they are written normally.
  - Zero-cycle latency when empty.
- Undefined: no bypass path; minimum latency is 1 cycle.

Test Plan:
- Reset, then 4 bundles of 2'b11 with PCs 0x1000..0x101C and dec_ready_i = 0 -> count_o = 8, fet_ready_o = 0 after the 4th; then dec_ready_i = 1 -> 4 consecutive pairs in PC order 0x1000/0x1004 ... 0x1018/0x101C.
- Count = 6, bundle 2'b11 with simultaneous dec_ready_i = 1 -> count_o = 6 next cycle; fet_ready_o depends only on the pre-dequeue count.
- Bundle 2'b10 with inst1 = 0x00500093 into empty queue -> next cycle dec_valid_o = 2'b01, dec_inst0_o = 0x00500093.
- Fill 5 entries, flush_i = 1 together with a valid bundle and dec_ready_i = 1 -> next cycle count_o = 0, dec_valid_o = 0, bundle discarded.
- Run 20 bundles with random dec_ready_i -> pointer wrap verified, output PC sequence strictly increasing by 4, no loss or duplication.
- With INST_QUEUE_BYPASS_EN: empty queue, bundle 2'b11, dec_ready_i = 1 -> dec_valid_o = 2'b11 in the same cycle, count_o stays 0. Without the macro -> dec_valid_o = 2'b11 one cycle later.

Source files
------------

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue -- instruction buffer between fetch and the two decode ways.
//
// A circular FIFO of DEPTH {inst, pc} entries. It accepts 2-wide fetch bundles,
// compacting any invalid slot, and presents the two oldest entries to decode in
// program order. flush_i empties the queue in a single cycle.
//
// Optional feature (macro INST_QUEUE_BYPASS_EN): when the queue is empty, an
// incoming bundle drives the decode outputs combinationally in the same cycle.
// If decode takes the bundle in that cycle, it is never written.
//
// Parameters:
//   DEPTH  number of entries (power of 2, >= 4)
//   PC_W   stored PC width
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i                   drop all queued entries and the incoming bundle
//   fet_valid_i[1:0]          per-slot valid of the fetch bundle (bit0 older)
//   fet_inst0/1_i, fet_pc0/1_i fetch bundle payload
//   fet_ready_o               room for a full bundle (count only)
//   dec_valid_o[1:0]          per-slot valid to decode (bit0 oldest)
//   dec_inst0/1_o, dec_pc0/1_o oldest / second-oldest entry
//   dec_ready_i               decode takes every valid output slot
//   count_o                   current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [1:0]               fet_valid_i,
  input  logic [31:0]              fet_inst0_i,
  input  logic [31:0]              fet_inst1_i,
  input  logic [PC_W-1:0]          fet_pc0_i,
  input  logic [PC_W-1:0]          fet_pc1_i,
  output logic                     fet_ready_o,
  output logic [1:0]               dec_valid_o,
  output logic [31:0]              dec_inst0_o,
  output logic [31:0]              dec_inst1_o,
  output logic [PC_W-1:0]          dec_pc0_o,
  output logic [PC_W-1:0]          dec_pc1_o,
  input  logic                     dec_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t          fet_slot [2];   // bundle after compaction, [0] oldest
  entry_t          rd_slot  [2];   // entries at rd_ptr, rd_ptr+1
  entry_t          out_slot [2];
  logic [1:0]      enq_n, deq_n;
  logic            enq_fire, byp_act, byp_consume, wr_en;

  // Compaction: a lone slot-1 instruction lands in the first free entry.
  always_comb begin
    fet_slot[0] = fet_valid_i[0] ? entry_t'{inst: fet_inst0_i, pc: fet_pc0_i}
                                 : entry_t'{inst: fet_inst1_i, pc: fet_pc1_i};
    fet_slot[1] = entry_t'{inst: fet_inst1_i, pc: fet_pc1_i};
    enq_n       = {1'b0, fet_valid_i[0]} + {1'b0, fet_valid_i[1]};
  end

  // Ready looks at the current count only; a same-cycle dequeue never helps.
  assign fet_ready_o = (count_q <= CW'(DEPTH - 2)) && !rst_i;
  assign enq_fire    = fet_ready_o && (|fet_valid_i);

`ifdef INST_QUEUE_BYPASS_EN
  assign byp_act = enq_fire && !flush_i && (count_q == '0);
`else
  assign byp_act = 1'b0;
`endif
  // Bypassed bundle taken by decode the same cycle: nothing is stored.
  assign byp_consume = byp_act && dec_ready_i;

  always_comb begin
    rd_slot[0] = mem_q[rd_ptr_q];
    rd_slot[1] = mem_q[rd_ptr_q + AW'(1)];
  end

  // Output selection. flush_i is deliberately not looked at here: the flush
  // cycle still shows the pre-flush contents.
  always_comb begin
    dec_valid_o = 2'b00;
    out_slot[0] = rd_slot[0];
    out_slot[1] = rd_slot[1];
    if (rst_i) begin
      dec_valid_o = 2'b00;
    end else if (byp_act) begin
      dec_valid_o = {fet_valid_i == 2'b11, 1'b1};
      out_slot[0] = fet_slot[0];
      out_slot[1] = fet_slot[1];
    end else begin
      dec_valid_o = {count_q >= CW'(2), count_q != '0};
    end
  end

  assign dec_inst0_o = out_slot[0].inst;
  assign dec_pc0_o   = out_slot[0].pc;
  assign dec_inst1_o = out_slot[1].inst;
  assign dec_pc1_o   = out_slot[1].pc;
  assign count_o     = count_q;

  assign deq_n = dec_ready_i ? ({1'b0, dec_valid_o[0]} + {1'b0, dec_valid_o[1]})
                             : 2'd0;
  assign wr_en = enq_fire && !flush_i && !byp_consume;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rst_i || flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (!byp_consume) begin
      rd_ptr_d = rd_ptr_q + AW'(deq_n);
      if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(enq_n);
      count_d  = count_q + (enq_fire ? CW'(enq_n) : CW'(0)) - CW'(deq_n);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= fet_slot[0];
      if (fet_valid_i == 2'b11) mem_q[wr_ptr_q + AW'(1)] <= fet_slot[1];
    end
  end

endmodule
